shift_seq: RTL
==============

Name: shift_seq

Overview:
- Sequencer that drives the 8-bit combinational shift unit from the control side.
- It accepts a command (direction, step count, operand) and drives fbus/flbus/frbus and the operand a.
- It captures w/cf back into a working register once per cycle, so multi-step rotates take one step per clock.
- Sits between the datapath controller and the shift unit; reports completion with a done pulse.

Parameters:
- WIDTH, 8, data width; must match the shift unit.
- CNT_W, 3, step-count width; max 2**CNT_W-1 steps.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- dir  in  2  00 pass, 01 rotate left, 10 rotate right, 11 illegal.
- count  in  CNT_W  number of rotate steps.
- din  in  WIDTH  operand.
- busy  out  1  high from the cycle after start accepted until DONE exits.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when dir=11.
- dout  out  WIDTH  working register; result valid when done=1, held until next accepted start.
- cf_out  out  1  captured carry flag.
- fbus  out  1  pass enable to shift unit.
- flbus  out  1  rotate-left enable to shift unit.
- frbus  out  1  rotate-right enable to shift unit.
- a  out  WIDTH  operand to shift unit; always equals dout.
- w  in  WIDTH  result from shift unit.
- cf  in  1  carry from shift unit.

Behaviour:
- Reset (async): state=IDLE; dout=0, cf_out=0, busy=0, done=0, err=0, fbus=flbus=frbus=0, count register=0.
- fbus/flbus/frbus are decoded only from state and latched mode, never from inputs. At most one is high in any cycle; all are 0 outside PASS/SHIFT, so the shift unit floats w.
- IDLE, start=1: latch dout<=din, mode<=dir, cnt<=count, cf_out<=0. Next state:
  - dir=11 -> DONE with err flag set.
  - dir=00, or count=0 with dir 01/10 -> PASS.
  - otherwise -> SHIFT.
- PASS (1 cycle): fbus=1; dout<=w; cf_out<=0; -> DONE.
- SHIFT: flbus=1 (mode 01) or frbus=1 (mode 10). Each cycle: dout<=w, cf_out<=cf, cnt<=cnt-1. When cnt==1 at this edge -> DONE.
  - Exactly N shift cycles for count=N.
  - cf_out reflects the last step only.
- DONE (1 cycle): done=1; err=1 iff mode=11; busy=0; -> IDLE. dout is unchanged on an illegal command beyond the din load.
- Latency: start edge E0; result in dout after E0+N+1 (shift) or E0+2 (pass). done is high during the cycle following the last capture.
- start while not IDLE: ignored, no queueing.
- start may be asserted in the cycle done is high; it is accepted on the next IDLE cycle only if still high.
- Reset mid-SHIFT: immediate return to IDLE with reset values; partial result discarded.
- Wrap-around: rotate semantics are owned by the shift unit; the sequencer only counts. count=2**CNT_W-1 is legal.

Decomposition:
- Package shift_pkg:
  - Direction encodings DIR_PASS=2'b00, DIR_LEFT=2'b01, DIR_RIGHT=2'b10, DIR_BAD=2'b11.
  - State typedef {IDLE, PASS, SHIFT, DONE}.
  - Default WIDTH/CNT_W constants.
- No sub-module inside shift_seq; the bench instantiates the existing shift unit wired to fbus/flbus/frbus/a/w/cf.

Test Plan:
- din=8'h81, dir=01, count=1 -> flbus high 1 cycle; dout=8'h03, cf_out=1, done at E0+2.
- din=8'h01, dir=10, count=3 -> frbus high 3 cycles; intermediates 80/40/20; dout=8'h20, cf_out=0, done at E0+4.
- din=8'hA5, dir=00 -> fbus high exactly 1 cycle; dout=8'hA5, cf_out=0. Also dir=01, count=0 -> identical.
- dir=11, din=8'h3C -> no bus enable ever high; done=1 and err=1 same cycle; dout=8'h3C.
- Long and interrupted runs:
  - dir=01, count=7, din=8'h01 -> dout=8'h80, cf_out=0.
  - Re-pulse start mid-run -> ignored; run completes unchanged.
  - Assert rst at step 4 -> all outputs 0, IDLE next edge, no done pulse.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings and defaults for the shift sequencer and its shift unit.
// Direction codes match the control-side command format.
package shift_pkg;

   localparam int SHIFT_WIDTH = 8;
   localparam int SHIFT_CNT_W = 3;

   localparam logic [1:0] DIR_PASS  = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;
   localparam logic [1:0] DIR_BAD   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/shift_seq.sv
// Sequencer driving the combinational shift unit: one rotate step per clock, result in dout.
// Latency: N+1 cycles start-to-done for N rotate steps, 2 for pass, 1 for an illegal direction.
module shift_seq
   import shift_pkg::*;
#(
   parameter int WIDTH = SHIFT_WIDTH,
   parameter int CNT_W = SHIFT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       dir,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] dout,
   output logic             cf_out,
   output logic             fbus,
   output logic             flbus,
   output logic             frbus,
   output logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] w,
   input  logic             cf
);

   state_t           state;
   logic [1:0]       mode;
   logic [CNT_W-1:0] cnt;

   // The shift unit always operates on the working register.
   assign a = dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         mode   <= DIR_PASS;
         cnt    <= '0;
         dout   <= '0;
         cf_out <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         fbus   <= 1'b0;
         flbus  <= 1'b0;
         frbus  <= 1'b0;
      end else begin
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         fbus  <= 1'b0;
         flbus <= 1'b0;
         frbus <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dout   <= din;
                  mode   <= dir;
                  cnt    <= count;
                  cf_out <= 1'b0;
                  if (dir == DIR_BAD) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (dir == DIR_PASS || count == '0) begin
                     state <= PASS;
                     busy  <= 1'b1;
                     fbus  <= 1'b1;
                  end else begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                     flbus <= (dir == DIR_LEFT);
                     frbus <= (dir == DIR_RIGHT);
                  end
               end
            end
            PASS: begin
               dout   <= w;
               cf_out <= 1'b0;
               state  <= DONE;
               done   <= 1'b1;
               err    <= (mode == DIR_BAD);
            end
            SHIFT: begin
               dout   <= w;
               cf_out <= cf;
               cnt    <= cnt - 1'b1;
               // cnt==1 means this edge captures the final step.
               if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                  state <= DONE;
                  done  <= 1'b1;
                  err   <= (mode == DIR_BAD);
               end else begin
                  busy  <= 1'b1;
                  flbus <= (mode == DIR_LEFT);
                  frbus <= (mode == DIR_RIGHT);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
